// File: rtl/add_nib_seq.sv
// add_nib_seq - nibble-serial adder/subtractor.
//
// Computes q = a + (sub ? ~b : b) + ci over WIDTH bits, one 4-bit slice per
// clock, least-significant nibble first. A single 4-bit adder is reused each
// cycle and the inter-nibble carry is held in a register. This trades latency
// (N+1 cycles from start to done, N = WIDTH/4) for a small datapath.
//
// Ports:
//   sys_clk  in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   request a new operation (accepted in IDLE or DONE only)
//   sub      in   0: a + b + ci, 1: a + ~b + ci
//   a, b     in   WIDTH-bit operands, sampled on the accepting edge
//   ci       in   carry-in, sampled on the accepting edge
//   busy     out  high while nibbles are being computed
//   done     out  one-cycle pulse, results valid
//   q        out  WIDTH-bit result (partial while busy)
//   co       out  carry out of bit WIDTH-1
//   ov       out  signed overflow (carry into MSB xor carry out of MSB)
//   z        out  result is zero
module add_nib_seq #(
  parameter int WIDTH = 16
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             ov,
  output logic             z
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            last;

  // Operand registers; b is stored already conditionally inverted.
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [5:0]       nib_res;
  logic [WIDTH-1:0] q_upd;

  // Returns {carry into bit 3, carry out of bit 3, 4-bit sum}. The carry into
  // bit 3 is only needed on the top nibble to form signed overflow.
  function automatic logic [5:0] nib_add(input logic [3:0] x,
                                         input logic [3:0] y,
                                         input logic       cin);
    logic [4:0] s;
    logic [3:0] lo;
    s  = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    lo = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, cin};
    return {lo[3], s};
  endfunction

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt == LAST);

  always_comb begin
    a_nib   = a_r[{cnt, 2'b00} +: 4];
    b_nib   = b_r[{cnt, 2'b00} +: 4];
    nib_res = nib_add(a_nib, b_nib, carry_r);
    q_upd   = q;
    q_upd[{cnt, 2'b00} +: 4] = nib_res[3:0];
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and visible result state.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= '0;
      co    <= 1'b0;
      ov    <= 1'b0;
      z     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= '0;
      end else if (state == RUN) begin
        q <= q_upd;
        // The counter wraps to 0 after the top nibble so it never indexes
        // past the operand registers.
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) begin
          co <= nib_res[4];
          ov <= nib_res[5] ^ nib_res[4];
          z  <= (q_upd == '0);
        end
      end
    end
  end

  // Operand and carry registers carry no reset: they are always loaded on the
  // accepting edge before being used.
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      a_r     <= a;
      b_r     <= sub ? ~b : b;
      carry_r <= ci;
    end else if (state == RUN) begin
      carry_r <= nib_res[4];
    end
  end

endmodule

// File: tb/tb_add_nib_seq.sv
// tb_add_nib_seq - directed bench for add_nib_seq (WIDTH=16 and WIDTH=4).
module tb_add_nib_seq;

  logic        sys_clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        busy;
  logic        done;
  logic [15:0] q;
  logic        co;
  logic        ov;
  logic        z;

  logic        start4;
  logic        sub4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        ci4;
  logic        busy4;
  logic        done4;
  logic [3:0]  q4;
  logic        co4;
  logic        ov4;
  logic        z4;

  int checks;
  int errors;

  add_nib_seq #(.WIDTH(16)) dut (
    .sys_clk(sys_clk), .rst(rst), .start(start), .sub(sub),
    .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .q(q), .co(co), .ov(ov), .z(z)
  );

  add_nib_seq #(.WIDTH(4)) dut4 (
    .sys_clk(sys_clk), .rst(rst), .start(start4), .sub(sub4),
    .a(a4), .b(b4), .ci(ci4),
    .busy(busy4), .done(done4), .q(q4), .co(co4), .ov(ov4), .z(z4)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic [15:0] q;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Run one 16-bit operation and check busy length, latency and results.
  task automatic run16(input vec_t v, input string tag);
    int nb;
    int guard;
    @(negedge sys_clk);
    a = v.a; b = v.b; ci = v.ci; sub = v.sub; start = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    start = 1'b0;
    // Operands must not be re-sampled after the accepting edge.
    a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
    nb = 0;
    guard = 0;
    while (!done && guard < 20) begin
      if (busy) nb++;
      guard++;
      @(negedge sys_clk);
    end
    chk({tag, " done_seen"}, 32'(done), 32'd1);
    chk({tag, " busy_cycles"}, nb, 4);
    chk({tag, " q"}, 32'(q), 32'(v.q));
    chk({tag, " co"}, 32'(co), 32'(v.co));
    chk({tag, " ov"}, 32'(ov), 32'(v.ov));
    chk({tag, " z"}, 32'(z), 32'(v.z));
    @(negedge sys_clk);
    chk({tag, " idle_done"}, {30'd0, busy, done}, 32'd0);
    chk({tag, " hold_q"}, {15'd0, q, co, ov, z}, {15'd0, v.q, v.co, v.ov, v.z});
  endtask

  initial begin
    int guard;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    start = 1'b0; sub = 1'b0; a = '0; b = '0; ci = 1'b0;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;

    vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0, 1'b0};

    // Reset state.
    #2 rst = 1'b1;
    #1;
    chk("reset16", {13'd0, busy, done, q, co, ov, z}, 32'd0);
    chk("reset4", {25'd0, busy4, done4, q4, co4, ov4, z4}, 32'd0);
    @(negedge sys_clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run16(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back with start held high; operands changed mid-RUN are ignored.
    @(negedge sys_clk);
    a = 16'h0001; b = 16'h0002; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1;
    guard = 0;
    while (!done && guard < 20) begin
      guard++;
      @(negedge sys_clk);
    end
    chk("b2b first done", 32'(done), 32'd1);
    chk("b2b first q", 32'(q), 32'h0003);
    a = 16'h0010; b = 16'h0020; ci = 1'b0;
    @(negedge sys_clk);
    chk("b2b no idle", {30'd0, busy, done}, 32'd2);
    a = 16'h5555; b = 16'h3333;
    repeat (3) @(negedge sys_clk);
    chk("b2b still busy", {30'd0, busy, done}, 32'd2);
    @(negedge sys_clk);
    chk("b2b second done", 32'(done), 32'd1);
    chk("b2b second q", 32'(q), 32'h0030);
    start = 1'b0;
    @(negedge sys_clk);
    chk("b2b idle", {30'd0, busy, done}, 32'd0);

    // Asynchronous reset during the second RUN cycle.
    a = 16'h1234; b = 16'h0FCD; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    start = 1'b0;
    @(negedge sys_clk);
    chk("pre-rst busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("async rst outs", {13'd0, busy, done, q, co, ov, z}, 32'd0);
    @(negedge sys_clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge sys_clk);
      chk("post-rst idle", {13'd0, busy, done, q, co, ov, z}, 32'd0);
    end
    run16(vecs[2], "after_rst");

    // WIDTH=4: done two cycles after start.
    @(negedge sys_clk);
    a4 = 4'hF; b4 = 4'h1; ci4 = 1'b0; sub4 = 1'b0; start4 = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    start4 = 1'b0;
    chk("w4 busy", {30'd0, busy4, done4}, 32'd2);
    @(negedge sys_clk);
    chk("w4 done", {30'd0, busy4, done4}, 32'd1);
    chk("w4 result", {25'd0, q4, co4, ov4, z4}, {25'd0, 4'h0, 1'b1, 1'b0, 1'b1});
    a4 = 4'h7; b4 = 4'h1; start4 = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    start4 = 1'b0;
    @(negedge sys_clk);
    chk("w4 b2b done", 32'(done4), 32'd1);
    chk("w4 ovf result", {25'd0, q4, co4, ov4, z4}, {25'd0, 4'h8, 1'b0, 1'b1, 1'b0});
    @(negedge sys_clk);
    chk("w4 idle", {30'd0, busy4, done4}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_nib_seq.md
Name: add_nib_seq

Overview:
- Parametrised nibble-serial adder/subtractor. It is the sequential successor to the 4-bit fa4r-based add4 slice.
- Processes a WIDTH-bit operand pair one 4-bit slice per clock, least-significant nibble first, through a single fa4r-equivalent slice with a registered carry.
- Used wherever a wide add/sub is needed at low gate cost and multi-cycle latency is acceptable, for example address/offset accumulation in TOM-side control logic.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4. Nibble count N = WIDTH/4.

Ports:
- sys_clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE or DONE.
- sub  in  1  0: q = a + b + ci; 1: q = a + ~b + ci (the caller sets ci=1 for a plain subtract).
- a  in  WIDTH  operand A; sampled on the accepting start edge.
- b  in  WIDTH  operand B; sampled on the accepting start edge.
- ci  in  1  carry-in; sampled on the accepting start edge.
- busy  out  1  high while nibbles are being computed (RUN).
- done  out  1  one-cycle pulse; results are valid.
- q  out  WIDTH  result.
- co  out  1  carry out of bit WIDTH-1.
- ov  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- z  out  1  1 when q == 0.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE; nibble counter = 0.
  - q = 0, co = 0, ov = 0, z = 0, busy = 0, done = 0.
  - An operation in progress is discarded and nothing resumes after rst deasserts.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- Accepting a start: on an edge with start=1 in IDLE or DONE:
  - Latch a, (sub ? ~b : b) and ci into internal registers.
  - Counter <= 0; next state RUN.
- RUN, each edge, with k = counter:
  - q[4k+3:4k] <= A[4k+3:4k] + B[4k+3:4k] + carry_reg.
  - carry_reg <= carry out of that nibble; counter <= k+1.
  - On the edge that computes k = N-1, also:
    - co <= nibble carry out;
    - ov <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1;
    - z <= (final q == 0);
    - next state DONE.
- Latency:
  - start sampled at edge E0; nibbles computed at edges E1..EN; done is high for the cycle after EN.
  - done asserts N+1 cycles after the cycle in which start was presented. For WIDTH=16 that is 5.
- q during RUN is partial and updates nibble by nibble. co, ov and z hold their previous values until the final nibble edge. Consumers use outputs only while done=1 or in the following IDLE.
- DONE lasts exactly one cycle:
  - start=1 in DONE starts a new operation back-to-back (DONE -> RUN).
  - Otherwise DONE -> IDLE.
- Hold in IDLE: q, co, ov and z keep the last result until the next accepted start.
- start in RUN is ignored. Operands are not re-sampled and the sequence is unaffected.
- a, b, ci and sub may change freely after the accepting edge.
- WIDTH=4 (N=1): RUN lasts one cycle; done appears 2 cycles after start is presented.
- Arithmetic is modulo 2^WIDTH. The carry chain spans nibbles only through carry_reg; there is no combinational path from a or b to the outputs.

Test Plan:
- WIDTH=16: a=0x1234, b=0x0FCD, ci=0, sub=0, start for 1 cycle -> busy for 4 cycles, then done one cycle with q=0x2201, co=0, ov=0, z=0.
- WIDTH=16: a=0xFFFF, b=0x0001, ci=0, sub=0 -> q=0x0000, co=1, ov=0, z=1.
- WIDTH=16: a=0x8000, b=0x0001, ci=1, sub=1 -> q=0x7FFF, co=1, ov=1, z=0.
- Start held high throughout, first pair 0x0001+0x0002 then 0x0010+0x0020 presented on the done cycle:
  - first done has q=0x0003; the second operation begins with no IDLE cycle;
  - second done 4 cycles later has q=0x0030;
  - a start pulse with different operands mid-RUN is ignored.
- Assert rst during the 2nd RUN cycle -> all outputs 0 immediately (asynchronous); state is IDLE after release; a following start operates normally.
- WIDTH=4 instance: a=0xF, b=0x1, ci=0 -> done 2 cycles after start with q=0x0, co=1, z=1.
